// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control codes, opcode/funct7 constants and the
//                M-op sequencer state type for the RV32IM ALU decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU operation codes; the 3-bit values match the existing core
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_code_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } seq_state_e;

    // Base (funct7 = 0) operation selected by funct3
    function automatic alu_code_e base_op(input logic [2:0] f3);
        alu_code_e r;
        case (f3)
            3'b000:  r = ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode
//  Description : Pure combinational ALUop/op/funct3/funct7 decode table.
//                Illegal encodings yield code 0 with the illegal flag set.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [1:0] alu_op,
    output logic [3:0] code,
    output logic       illegal,
    output logic       is_mop
);

    // Decode table; code stays ADD (0) on every illegal path
    always_comb begin
        code    = ALU_ADD;
        illegal = 1'b0;
        is_mop  = 1'b0;
        case (alu_op)
            2'b00: code = ALU_ADD;
            2'b01: code = ALU_SUB;
            2'b10: begin
                if (op == OP_RTYPE) begin
                    if (funct7 == F7_BASE) begin
                        code = base_op(funct3);
                    end else if (funct7 == F7_ALT) begin
                        if (funct3 == 3'b000)      code    = ALU_SUB;
                        else if (funct3 == 3'b101) code    = ALU_SRA;
                        else                       illegal = 1'b1;
                    end else if (funct7 == F7_MULDIV) begin
                        // M-ops use the adder slot; the MDU produces the result
                        if (ENABLE_M != 0) is_mop  = 1'b1;
                        else               illegal = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (op == OP_ITYPE) begin
                    case (funct3)
                        3'b000: code = ALU_ADD;
                        3'b001: begin
                            if (funct7 == F7_BASE) code    = ALU_SLL;
                            else                   illegal = 1'b1;
                        end
                        3'b101: begin
                            if (funct7 == F7_BASE)     code    = ALU_SRL;
                            else if (funct7 == F7_ALT) code    = ALU_SRA;
                            else                       illegal = 1'b1;
                        end
                        // funct7 bits are immediate bits for these forms
                        default: code = base_op(funct3);
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder_seq
//  Description : RV32IM ALU decoder with M-extension sequencer. Issues an MDU
//                start pulse, stalls the pipeline for the op duration and
//                flags a sticky divider timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder_seq
    import alu_pkg::*;
#(
    parameter int CTRL_W      = 4,
    parameter int ENABLE_M    = 1,
    parameter int MUL_CYCLES  = 2,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_valid,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [1:0]        ALUop,
    input  logic              mdu_done,
    output logic [CTRL_W-1:0] alu_control,
    output logic              illegal,
    output logic              mdu_start,
    output logic [2:0]        mdu_op,
    output logic              stall,
    output logic              result_sel,
    output logic              div_timeout
);

    localparam int C_CNT_MAX = (MUL_CYCLES > DIV_TIMEOUT) ? MUL_CYCLES : DIV_TIMEOUT;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX) + 1;
    localparam logic [C_CNT_W-1:0] C_MUL_LOAD = C_CNT_W'(MUL_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_DIV_LAST = C_CNT_W'(DIV_TIMEOUT - 1);

    logic [3:0]         w_code;
    logic               w_illegal;
    logic               w_is_mop;

    seq_state_e         r_state;
    seq_state_e         w_state_next;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_next;
    logic [2:0]         r_mdu_op;
    logic               r_div_timeout;
    logic               w_start;
    logic               w_stall;
    logic               w_result_sel;
    logic               w_set_timeout;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .op      (op),
        .funct3  (funct3),
        .funct7  (funct7),
        .alu_op  (ALUop),
        .code    (w_code),
        .illegal (w_illegal),
        .is_mop  (w_is_mop)
    );

    // Sequencer next-state, counter update and per-state control outputs
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_start       = 1'b0;
        w_stall       = 1'b0;
        w_result_sel  = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only IDLE may launch: the instruction is held while stalled
                if (instr_valid && w_is_mop) begin
                    w_start = 1'b1;
                    w_stall = 1'b1;
                    if (!funct3[2]) begin
                        w_cnt_next   = C_MUL_LOAD;
                        w_state_next = ST_MUL_WAIT;
                    end else begin
                        w_cnt_next   = '0;
                        w_state_next = ST_DIV_WAIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == '0) w_state_next = ST_DONE;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            ST_DIV_WAIT: begin
                w_stall    = 1'b1;
                w_cnt_next = r_cnt + 1'b1;
                // Completion takes priority over a coincident timeout
                if (mdu_done) begin
                    w_state_next = ST_DONE;
                end else if (r_cnt == C_DIV_LAST) begin
                    w_set_timeout = 1'b1;
                    w_state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_result_sel = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, counter, latched M-op and sticky timeout registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_mdu_op      <= 3'b000;
            r_div_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_start)       r_mdu_op      <= funct3;
            if (w_set_timeout) r_div_timeout <= 1'b1;
        end
    end

    // Control outputs are forced low during reset, before the state clears
    assign mdu_start   = reset_n & w_start;
    assign stall       = reset_n & w_stall;
    assign result_sel  = reset_n & w_result_sel;
    assign illegal     = instr_valid & w_illegal;
    assign alu_control = CTRL_W'(w_code);
    assign mdu_op      = r_mdu_op;
    assign div_timeout = r_div_timeout;

endmodule
`default_nettype wire
